// File: rtl/present_masking_pkg.sv
// Shared constants for the masked PRESENT affine datapath: lane/share widths and affine mode encodings.
package present_masking_pkg;

   localparam int unsigned LANE_W    = 4;
   localparam int unsigned MODE_W    = 2;
   localparam int unsigned MAX_SHARES = 4;

   typedef enum logic [MODE_W-1:0] {
      AFF_ID  = 2'd0,
      AFF_IN  = 2'd1,
      AFF_OUT = 2'd2,
      AFF_MID = 2'd3
   } aff_mode_e;

endpackage

// File: rtl/present_affine_nibble.sv
// One share of one 4-bit lane through the selected affine map; i_c adds the affine constant (share 0 only).
module present_affine_nibble
   import present_masking_pkg::*;
(
   input  logic [LANE_W-1:0] i_x,
   input  aff_mode_e         i_mode,
   input  logic              i_c,
   output logic [LANE_W-1:0] o_y_c
);

   always_comb begin
      o_y_c = i_x;
      case (i_mode)
         AFF_IN:  o_y_c = {i_x[1] ^ i_x[2] ^ i_c, i_x[1], i_x[3], i_x[0]};
         AFF_OUT: o_y_c = {i_x[1] ^ i_c, i_x[2] ^ i_x[3], i_x[0], i_x[2]};
         AFF_MID: o_y_c = {i_x[0] ^ i_x[2] ^ i_c, i_x[0], i_x[1], i_x[1] ^ i_x[3]};
         default: o_y_c = i_x;
      endcase
   end

endmodule

// File: rtl/present_affine_stage.sv
// Single-entry registered affine stage over SHARES x NIBBLES masked lanes with valid/ready handshake.
// Optional mask refresh before the output register is enabled by defining AFFINE_REFRESH_EN.
module present_affine_stage
   import present_masking_pkg::*;
#(
   parameter int unsigned SHARES  = 3,
   parameter int unsigned NIBBLES = 16
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [SHARES*LANE_W*NIBBLES-1:0]   in_shares,
   input  logic [MODE_W-1:0]                  in_mode,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [SHARES*LANE_W*NIBBLES-1:0]   out_shares,
   output logic                               out_valid,
`ifdef AFFINE_REFRESH_EN
   input  logic [(SHARES-1)*LANE_W*NIBBLES-1:0] rand_in,
`endif
   input  logic                               out_ready
);

   localparam int unsigned SHARE_W = LANE_W * NIBBLES;
   localparam int unsigned DATA_W  = SHARES * SHARE_W;

   logic [DATA_W-1:0] r_shares;
   logic              r_valid;
   logic [DATA_W-1:0] w_aff;
   logic [DATA_W-1:0] w_mask;
   logic              w_accept;
   aff_mode_e         w_mode;

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_mode   = aff_mode_e'(in_mode);

   // Each share/lane is processed independently so shares never mix.
   for (genvar s = 0; s < SHARES; s++) begin : g_share
      for (genvar n = 0; n < NIBBLES; n++) begin : g_lane
         present_affine_nibble u_nib (
            .i_x    (in_shares[(s*NIBBLES+n)*LANE_W +: LANE_W]),
            .i_mode (w_mode),
            .i_c    (1'(s == 0)),
            .o_y_c  (w_aff[(s*NIBBLES+n)*LANE_W +: LANE_W])
         );
      end
   end

`ifdef AFFINE_REFRESH_EN
   logic [SHARE_W-1:0] w_last;

   // Last share absorbs the XOR of all fresh masks so the unmasked value is preserved.
   always_comb begin
      w_last = '0;
      for (int s = 0; s < int'(SHARES) - 1; s++) begin
         w_last = w_last ^ rand_in[s*SHARE_W +: SHARE_W];
      end
   end

   assign w_mask = {w_last, rand_in};
`else
   assign w_mask = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shares <= '0;
         r_valid  <= 1'b0;
      end else if (w_accept) begin
         r_shares <= w_aff ^ w_mask;
         r_valid  <= 1'b1;
      end else if (out_ready) begin
         r_valid  <= 1'b0;
      end
   end

   assign out_shares = r_shares;
   assign out_valid  = r_valid;

endmodule

// File: tb/tb_present_affine_stage.sv
// Scoreboard bench for present_affine_stage; reference model works on whole nibbles from the affine definitions.
module tb_present_affine_stage;
   import present_masking_pkg::*;

   localparam int unsigned SH = 3;
   localparam int unsigned NB = 16;
   localparam int unsigned LW = NB * LANE_W;
   localparam int unsigned W  = SH * LW;
   localparam int unsigned RW = (SH - 1) * LW;
`ifdef AFFINE_REFRESH_EN
   localparam bit REFRESH = 1'b1;
`else
   localparam bit REFRESH = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]  shares;
      logic [LW-1:0] plain;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  in_shares;
   logic [1:0]    in_mode;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_shares;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] rand_in;

   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;
   int   cyc    = 0;
   bit   burst  = 1'b0;
   bit   bp_rand = 1'b0;
   exp_t sb_q[$];
   int   stamp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   present_affine_stage #(.SHARES(SH), .NIBBLES(NB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_shares  (in_shares),
      .in_mode    (in_mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_shares (out_shares),
      .out_valid  (out_valid),
`ifdef AFFINE_REFRESH_EN
      .rand_in    (rand_in),
`endif
      .out_ready  (out_ready)
   );

   // Affine maps of the cipher on a single nibble; c is the additive constant.
   function automatic logic [3:0] aff(input logic [3:0] x, input int m, input logic c);
      logic [3:0] y;
      case (m)
         1: y = {x[1] ^ x[2] ^ c, x[1], x[3], x[0]};
         2: y = {x[1] ^ c, x[2] ^ x[3], x[0], x[2]};
         3: y = {x[0] ^ x[2] ^ c, x[0], x[1], x[1] ^ x[3]};
         default: y = x;
      endcase
      return y;
   endfunction

   function automatic logic [LW-1:0] unmask(input logic [W-1:0] x);
      logic [LW-1:0] acc = '0;
      for (int s = 0; s < int'(SH); s++) acc ^= x[s*LW +: LW];
      return acc;
   endfunction

   function automatic exp_t model(input logic [W-1:0] x, input int m, input logic [RW-1:0] r);
      exp_t          e;
      logic [LW-1:0] acc = '0;
      logic [LW-1:0] p;
      for (int s = 0; s < int'(SH); s++)
         for (int n = 0; n < int'(NB); n++)
            e.shares[(s*NB+n)*4 +: 4] = aff(x[(s*NB+n)*4 +: 4], m, s == 0);
      if (REFRESH) begin
         for (int s = 0; s < int'(SH) - 1; s++) begin
            e.shares[s*LW +: LW] ^= r[s*LW +: LW];
            acc ^= r[s*LW +: LW];
         end
         e.shares[(SH-1)*LW +: LW] ^= acc;
      end
      p = unmask(x);
      for (int n = 0; n < int'(NB); n++) e.plain[n*4 +: 4] = aff(p[n*4 +: 4], m, 1'b1);
      return e;
   endfunction

   function automatic logic [RW-1:0] rnd_rand();
      logic [RW-1:0] r;
      for (int i = 0; i < int'(RW); i += 32) r[i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_data();
      logic [W-1:0] r;
      for (int i = 0; i < int'(W); i += 32) r[i +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Monitor: a transfer completes at the next rising edge whenever out_valid && out_ready here.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h with empty scoreboard", out_shares);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("out_shares", out_shares, e.shares);
            check("unmasked", W'(unmask(out_shares)), W'(e.plain));
         end
         n_out++;
         if (burst) stamp_q.push_back(cyc);
      end
   end

   // Offer one transaction; returns at posedge+1 right after it was accepted.
   task automatic send(input logic [W-1:0] x, input logic [1:0] m, input logic [RW-1:0] r);
      int t = 0;
      in_shares = x;
      in_mode   = m;
      rand_in   = r;
      in_valid  = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(model(x, int'(m), rand_in));
            break;
         end
         t++;
         if (t > 60) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b want 1", in_ready);
            break;
         end
         @(posedge clk);
         #1;
         if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while (sb_q.size() != 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding want 0", sb_q.size());
      end
   endtask

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] o1;
      logic [W-1:0] o2;
      exp_t         e;
      int           n0;
      int           bad;

      rst_n = 1'b0; in_valid = 1'b0; in_shares = '0; in_mode = 2'd0;
      out_ready = 1'b0; rand_in = '0;
      #12;
      check("reset_out_valid", W'(out_valid), W'(0));
      check("reset_out_shares", out_shares, '0);
      check("reset_in_ready", W'(in_ready), W'(1));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Worked example on lane 0: shares (5,3,6), input affine, known outputs (1,D,4).
      out_ready = 1'b1;
      x = '0;
      x[0*LW +: 4] = 4'h5; x[1*LW +: 4] = 4'h3; x[2*LW +: 4] = 4'h6;
      send(x, 2'd1, '0);
      check("lat1_valid", W'(out_valid), W'(1));
      if (!REFRESH) begin
         check("ex_share0", W'(out_shares[0*LW +: 4]), W'(4'h1));
         check("ex_share1", W'(out_shares[1*LW +: 4]), W'(4'hD));
         check("ex_share2", W'(out_shares[2*LW +: 4]), W'(4'h4));
      end
      check("ex_unmasked", W'(unmask(out_shares) & LW'(4'hF)), W'(4'h8));
      drain();

      // All 16 values in every lane position x 4 modes with random sharing and back-pressure.
      bp_rand = 1'b1;
      for (int v = 0; v < 16; v++) begin
         for (int m = 0; m < 4; m++) begin
            logic [LW-1:0] plain;
            logic [LW-1:0] acc;
            for (int n = 0; n < int'(NB); n++) plain[n*4 +: 4] = 4'((v + n) % 16);
            x = rnd_data();
            acc = '0;
            for (int s = 0; s < int'(SH) - 1; s++) acc ^= x[s*LW +: LW];
            x[(SH-1)*LW +: LW] = acc ^ plain;
            send(x, 2'(m), rnd_rand());
         end
      end
      bp_rand = 1'b0;
      drain();

      // Stall: result must hold for 5 cycles while a competing offer is refused.
      out_ready = 1'b0;
      x = rnd_data();
      e = model(x, 3, rnd_rand());
      send(x, 2'd3, rand_in);
      e = model(x, 3, rand_in);
      in_shares = rnd_data(); in_mode = 2'd2; in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_shares !== e.shares || in_ready !== 1'b0) begin
            errors++; bad++;
            $display("FAIL stall_hold: valid=%b ready=%b shares=%h want 1 0 %h",
                     out_valid, in_ready, out_shares, e.shares);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n0 = n_out;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("stall_release_count", W'(n_out - n0), W'(1));
      check("stall_release_empty", W'(sb_q.size()), W'(0));

      // Full-throughput burst of 100 back-to-back transactions.
      stamp_q.delete();
      burst = 1'b1;
      for (int i = 0; i < 100; i++) send(rnd_data(), 2'($urandom_range(0, 3)), rnd_rand());
      repeat (3) @(posedge clk);
      #1;
      burst = 1'b0;
      check("burst_count", W'(stamp_q.size()), W'(100));
      bad = 0;
      for (int i = 1; i < stamp_q.size(); i++) if (stamp_q[i] != stamp_q[i-1] + 1) bad++;
      check("burst_gaps", W'(bad), W'(0));

`ifdef AFFINE_REFRESH_EN
      // Same input, fresh masks: shares must change while the unmasked value does not.
      x = rnd_data();
      send(x, 2'd1, rnd_rand());
      o1 = out_shares;
      send(x, 2'd1, ~rand_in);
      o2 = out_shares;
      checks++;
      if (o1 === o2) begin
         errors++;
         $display("FAIL refresh_diff: got %h twice want differing shares", o1);
      end
      check("refresh_unmasked", W'(unmask(o2)), W'(unmask(o1)));
      drain();
`else
      o1 = '0; o2 = '0;
`endif

      // Reset while a result is held: cleared immediately and never emitted.
      out_ready = 1'b0;
      send(rnd_data(), 2'd2, rnd_rand());
      check("pre_reset_valid", W'(out_valid), W'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midreset_valid", W'(out_valid), W'(0));
      check("midreset_shares", out_shares, '0);
      check("midreset_in_ready", W'(in_ready), W'(1));
      sb_q.delete();
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      n0 = n_out;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_reset_no_output", W'(n_out - n0), W'(0));
      check("post_reset_valid", W'(out_valid), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
